// File: rtl/store_rmw_ctrl.sv
// store_rmw_ctrl: sw/sh/sb store sequencer with read-modify-write for sh/sb.
// Ports: clk, reset_n, start/store_ctrl/addr_in/b_in request inputs,
//   mem_rdata read data in; mem_addr/mem_wdata/mem_wr memory pins out;
//   busy, done, err_type status. Optional macro STORE_ALIGN_CHECK_EN
//   adds err_align and rejects misaligned sw/sh.
module store_rmw_ctrl #(
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  store_ctrl,
  input  logic [31:0] addr_in,
  input  logic [31:0] b_in,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wr,
  output logic        busy,
  output logic        done,
`ifdef STORE_ALIGN_CHECK_EN
  output logic        err_align,
`endif
  output logic        err_type
);

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    WRITE,
    DONE,
    ERR
  } state_t;

  localparam logic [1:0] SW = 2'b00;
  localparam logic [1:0] SH = 2'b01;
  localparam logic [1:0] SB = 2'b10;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [15:0]       b_q, b_d;
  logic [1:0]        ctrl_q, ctrl_d;
  logic              mis;

`ifdef STORE_ALIGN_CHECK_EN
  logic              align_q, align_d;

  assign mis = ((store_ctrl == SW) && (addr_in[1:0] != 2'b00))
            || ((store_ctrl == SH) && addr_in[0]);
`else
  assign mis = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    b_d     = b_q;
    ctrl_d  = ctrl_q;
`ifdef STORE_ALIGN_CHECK_EN
    align_d = align_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
`ifdef STORE_ALIGN_CHECK_EN
          align_d = mis;
`endif
          if (mis || (store_ctrl == 2'b11)) begin
            state_d = ERR;
          end else if (store_ctrl == SW) begin
            addr_d  = addr_in;
            wdata_d = b_in;
            state_d = WRITE;
          end else begin
            addr_d  = addr_in;
            b_d     = b_in[15:0];
            ctrl_d  = store_ctrl;
            cnt_d   = CNT_W'(MEM_LAT);
            state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        // Last wait cycle: read data is valid now, merge it.
        if (cnt_q == CNT_W'(1)) begin
          if (ctrl_q == SB)
            wdata_d = {mem_rdata[31:8], b_q[7:0]};
          else
            wdata_d = {mem_rdata[31:16], b_q};
          state_d = WRITE;
        end
      end
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      b_q     <= '0;
      ctrl_q  <= SW;
`ifdef STORE_ALIGN_CHECK_EN
      align_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      b_q     <= b_d;
      ctrl_q  <= ctrl_d;
`ifdef STORE_ALIGN_CHECK_EN
      align_q <= align_d;
`endif
    end
  end

  // Decoded from state so reset clears them asynchronously.
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wr    = (state_q == WRITE);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
`ifdef STORE_ALIGN_CHECK_EN
  assign err_align = (state_q == ERR) && align_q;
  assign err_type  = (state_q == ERR) && !align_q;
`else
  assign err_type  = (state_q == ERR);
`endif

endmodule

// File: tb/tb_store_rmw_ctrl.sv
// tb_store_rmw_ctrl: directed bench for store_rmw_ctrl.
// Two instances: MEM_LAT=1 (dut1) and MEM_LAT=3 (dut3).
module tb_store_rmw_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start1, start3;
  logic [1:0]  ctrl;
  logic [31:0] addr, b;

  logic [31:0] a1, wd1, rd1;
  logic        wr1, busy1, done1, err1;
  logic [31:0] a3, wd3, rd3;
  logic        wr3, busy3, done3, err3;
`ifdef STORE_ALIGN_CHECK_EN
  logic        al1, al3;
`endif

  int passes = 0;
  int total  = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] ad);
    case (ad)
      32'h80:  memf = 32'h11223344;
      32'h84:  memf = 32'h55667788;
      default: memf = 32'hA5A5A5A5;
    endcase
  endfunction

  logic [31:0] pipe3 [0:1];
  initial begin
    pipe3[0] = 32'h0;
    pipe3[1] = 32'h0;
  end
  always @(posedge clk) begin
    pipe3[0] <= memf(a3);
    pipe3[1] <= pipe3[0];
  end
  assign rd1 = memf(a1);
  assign rd3 = pipe3[1];

  store_rmw_ctrl #(.MEM_LAT(1), .CNT_W(3)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1),
    .store_ctrl(ctrl), .addr_in(addr), .b_in(b),
    .mem_rdata(rd1), .mem_addr(a1), .mem_wdata(wd1),
    .mem_wr(wr1), .busy(busy1), .done(done1),
`ifdef STORE_ALIGN_CHECK_EN
    .err_align(al1),
`endif
    .err_type(err1)
  );

  store_rmw_ctrl #(.MEM_LAT(3), .CNT_W(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .start(start3),
    .store_ctrl(ctrl), .addr_in(addr), .b_in(b),
    .mem_rdata(rd3), .mem_addr(a3), .mem_wdata(wd3),
    .mem_wr(wr3), .busy(busy3), .done(done3),
`ifdef STORE_ALIGN_CHECK_EN
    .err_align(al3),
`endif
    .err_type(err3)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [8:0] wrv, dnv;
  logic       both, any_wr, any_dn;

  initial begin
    reset_n = 1'b0;
    start1  = 1'b0;
    start3  = 1'b0;
    ctrl    = 2'b00;
    addr    = 32'h0;
    b       = 32'h0;

    @(negedge clk);
    chk("rst_addr", a1, 32'h0);
    chk("rst_wdata", wd1, 32'h0);
    chk("rst_wr", {31'h0, wr1}, 32'h0);
    chk("rst_busy", {31'h0, busy1}, 32'h0);
    chk("rst_done", {31'h0, done1}, 32'h0);
    chk("rst_err", {31'h0, err1}, 32'h0);
    reset_n = 1'b1;

    // sw, MEM_LAT=1
    @(negedge clk);
    start1 = 1'b1; ctrl = 2'b00;
    addr = 32'h40; b = 32'hDEADBEEF;
    cyc();
    start1 = 1'b0;
    chk("sw_wr_c1", {31'h0, wr1}, 32'h1);
    chk("sw_addr_c1", a1, 32'h40);
    chk("sw_wdata_c1", wd1, 32'hDEADBEEF);
    chk("sw_done_c1", {31'h0, done1}, 32'h0);
    cyc();
    chk("sw_done_c2", {31'h0, done1}, 32'h1);
    chk("sw_wr_c2", {31'h0, wr1}, 32'h0);
    cyc();
    chk("sw_idle_c3", {31'h0, busy1}, 32'h0);

    // sh, MEM_LAT=1
    @(negedge clk);
    start1 = 1'b1; ctrl = 2'b01;
    addr = 32'h80; b = 32'hAABBCCDD;
    cyc();
    start1 = 1'b0;
    chk("sh_wr_c1", {31'h0, wr1}, 32'h0);
    chk("sh_busy_c1", {31'h0, busy1}, 32'h1);
    chk("sh_addr_c1", a1, 32'h80);
    cyc();
    chk("sh_wr_c2", {31'h0, wr1}, 32'h1);
    chk("sh_wdata_c2", wd1, 32'h1122CCDD);
    cyc();
    chk("sh_done_c3", {31'h0, done1}, 32'h1);
    chk("sh_wr_c3", {31'h0, wr1}, 32'h0);
    cyc();
    chk("sh_idle_c4", {31'h0, busy1}, 32'h0);

    // sb, MEM_LAT=3, inputs change after accept
    @(negedge clk);
    start3 = 1'b1; ctrl = 2'b10;
    addr = 32'h84; b = 32'h000000EE;
    cyc();
    start3 = 1'b0;
    addr = 32'h80; b = 32'hFFFFFFFF; ctrl = 2'b01;
    chk("sb_wr_c1", {31'h0, wr3}, 32'h0);
    cyc();
    chk("sb_wr_c2", {31'h0, wr3}, 32'h0);
    cyc();
    chk("sb_wr_c3", {31'h0, wr3}, 32'h0);
    cyc();
    chk("sb_wr_c4", {31'h0, wr3}, 32'h1);
    chk("sb_addr_c4", a3, 32'h84);
    chk("sb_wdata_c4", wd3, 32'h556677EE);
    cyc();
    chk("sb_done_c5", {31'h0, done3}, 32'h1);
    chk("sb_wr_c5", {31'h0, wr3}, 32'h0);
    cyc();
    chk("sb_idle_c6", {31'h0, busy3}, 32'h0);

    // illegal store type
    @(negedge clk);
    start1 = 1'b1; ctrl = 2'b11; addr = 32'h100;
    cyc();
    start1 = 1'b0;
    chk("ill_err_c1", {31'h0, err1}, 32'h1);
    chk("ill_wr_c1", {31'h0, wr1}, 32'h0);
    chk("ill_busy_c1", {31'h0, busy1}, 32'h1);
    cyc();
    chk("ill_busy_c2", {31'h0, busy1}, 32'h0);
    chk("ill_err_c2", {31'h0, err1}, 32'h0);
    chk("ill_done_c2", {31'h0, done1}, 32'h0);

    // start held high: accepts every third cycle
    @(negedge clk);
    start1 = 1'b1; ctrl = 2'b00;
    addr = 32'h10; b = 32'h12345678;
    wrv = '0; dnv = '0; both = 1'b0;
    for (int i = 0; i < 9; i++) begin
      cyc();
      wrv[i] = wr1;
      dnv[i] = done1;
      if (wr1 && done1) both = 1'b1;
    end
    start1 = 1'b0;
    chk("b2b_wr_pat", {23'h0, wrv}, {23'h0, 9'b001001001});
    chk("b2b_done_pat", {23'h0, dnv}, {23'h0, 9'b010010010});
    chk("b2b_overlap", {31'h0, both}, 32'h0);
    cyc(); cyc(); cyc();
    chk("b2b_idle", {31'h0, busy1}, 32'h0);

    // reset while sh waits for read data
    @(negedge clk);
    start3 = 1'b1; ctrl = 2'b01;
    addr = 32'h80; b = 32'h0000BEEF;
    cyc();
    start3 = 1'b0;
    chk("rmid_busy", {31'h0, busy3}, 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rmid_busy0", {31'h0, busy3}, 32'h0);
    chk("rmid_addr0", a3, 32'h0);
    chk("rmid_wr0", {31'h0, wr3}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    any_wr = 1'b0; any_dn = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (wr3) any_wr = 1'b1;
      if (done3) any_dn = 1'b1;
    end
    chk("rmid_no_wr", {31'h0, any_wr}, 32'h0);
    chk("rmid_no_done", {31'h0, any_dn}, 32'h0);

`ifdef STORE_ALIGN_CHECK_EN
    @(negedge clk);
    start1 = 1'b1; ctrl = 2'b01; addr = 32'h41;
    cyc();
    start1 = 1'b0;
    chk("al_pulse", {31'h0, al1}, 32'h1);
    chk("al_type", {31'h0, err1}, 32'h0);
    chk("al_wr", {31'h0, wr1}, 32'h0);
    cyc();
    chk("al_idle", {31'h0, busy1}, 32'h0);
    chk("al_clear", {31'h0, al1}, 32'h0);
`endif

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/store_rmw_ctrl.md
Name: store_rmw_ctrl

Overview:
- Sequencer that executes sw/sh/sb against a word-wide memory with a registered read port.
- sh/sb run a read-modify-write: read the memory word, merge the low bits of B, write the word back. sw writes B directly.
- Sits between the main control FSM (which pulses start) and the memory Wr/Address/Datain pins.
- Merge semantics match the existing store-size datapath: sh keeps mem[31:16] and takes B[15:0]; sb keeps mem[31:8] and takes B[7:0].

Parameters:
- MEM_LAT, 1, read latency in cycles from mem_addr valid to mem_rdata valid (legal range 1..7).
- CNT_W, 3, width of the internal wait counter (must hold MEM_LAT).

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request pulse from the control FSM
- store_ctrl  input  2  00=sw, 01=sh, 10=sb, 11=illegal
- addr_in  input  32  store address
- b_in  input  32  store data (register B)
- mem_rdata  input  32  memory read data
- mem_addr  output  32  memory address
- mem_wdata  output  32  memory write data
- mem_wr  output  1  memory write enable
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle completion pulse
- err_type  output  1  one-cycle pulse for an illegal store_ctrl

Behaviour:
- Reset values (async, reset_n low): state=IDLE; mem_addr=0, mem_wdata=0, mem_wr=0, busy=0, done=0, err_type=0; wait counter=0.
- States: IDLE, RD_WAIT, WRITE, DONE, ERR.
- Request acceptance:
  - start is sampled only in IDLE.
  - start is ignored in every other state, including DONE and ERR; no queuing.
  - On accept, addr_in, b_in and store_ctrl are latched. Later changes to these inputs have no effect.
- IDLE + start, store_ctrl=00 -> WRITE; mem_wdata=b_in.
- IDLE + start, store_ctrl=01/10 -> RD_WAIT; counter=MEM_LAT.
- IDLE + start, store_ctrl=11 -> ERR.
- RD_WAIT:
  - mem_addr holds the latched address and mem_wr=0.
  - The counter decrements every cycle.
  - In the cycle the counter reaches 1, mem_rdata is sampled and the merge is registered into mem_wdata (sh: {rdata[31:16],B[15:0]}; sb: {rdata[31:8],B[7:0]}). The FSM then moves to WRITE.
  - RD_WAIT lasts exactly MEM_LAT cycles.
- WRITE: mem_wr=1 for exactly one cycle, with mem_addr and mem_wdata stable; next state is DONE.
- DONE: done=1 for one cycle; next state is IDLE. mem_addr and mem_wdata hold their values until the next accept.
- ERR: err_type=1 for one cycle with no memory write; next state is IDLE. done is not asserted.
- Latency, counted from the accepting clock edge:
  - sw: mem_wr in cycle 1, done in cycle 2.
  - sh/sb: mem_wr in cycle 1+MEM_LAT, done in cycle 2+MEM_LAT.
- mem_wr and done are never high together. mem_wr is high at most once per request.
- Reset mid-operation:
  - mem_wr drops immediately and the FSM returns to IDLE.
  - A write whose WRITE cycle has not yet been reached never occurs.
  - done is not emitted for the aborted request.
- Bits of mem_rdata that are not replaced pass through unchanged. No sign or zero extension.

Optional Feature:
- Macro: STORE_ALIGN_CHECK_EN.
- When defined:
  - Adds output err_align (1 bit, reset 0).
  - On accept, sw with addr_in[1:0]!=0, or sh with addr_in[0]!=0, goes to ERR with no memory access.
  - In ERR, err_align pulses one cycle instead of err_type.
  - sb is never misaligned.
- When undefined:
  - No alignment check and no err_align port.
  - All addresses proceed normally.

Test Plan:
- sw, MEM_LAT=1: start, store_ctrl=00, addr=0x40, B=0xDEADBEEF -> mem_wr=1 in cycle 1 with mem_addr=0x40, mem_wdata=0xDEADBEEF; done in cycle 2; no read wait.
- sh, MEM_LAT=1: memory[0x80]=0x11223344, B=0xAABBCCDD -> RD_WAIT 1 cycle; mem_wr in cycle 2 with mem_wdata=0x1122CCDD; done in cycle 3.
- sb, MEM_LAT=3: memory[0x84]=0x55667788, B=0x000000EE -> mem_wr in cycle 4 with mem_wdata=0x556677EE; done in cycle 5; B and addr_in changed after accept have no effect.
- Illegal type: store_ctrl=11 -> err_type pulses in cycle 1; mem_wr never asserts; busy returns low in cycle 2.
- Back-to-back and ignored start: start held high continuously -> each request's mem_wr/done pair completes before the next accept; start during DONE is not accepted; exactly one mem_wr per accepted request.
- Reset mid-op: sh in RD_WAIT, reset_n pulsed low -> outputs go to 0 asynchronously; no mem_wr; no done. With STORE_ALIGN_CHECK_EN, sh at addr 0x41 -> err_align pulse; no write.
